// File: rtl/inscyc_control_unit.sv
// inscyc_control_unit
//   Control-unit FSM for the 8-bit EC-1-style processor. It sequences the
//   start / fetch / decode / execute cycle of every instruction and drives
//   the instruction-cycle datapath. The outputs are Moore outputs, except
//   Aload in INPUT, which follows Enter combinationally.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous active-high reset (state START, counter 0)
//   IR       in   opcode IR[7:5], sampled only in DECODE
//   Aeq0     in   accumulator == 0 (used by JZ)
//   Apos     in   accumulator > 0 (used by JPOS)
//   Enter    in   user input-ready strobe (level sensitive, used by INPUT)
//   IRload   out  load instruction register
//   JMPmux   out  PC source: 0 = PC+1, 1 = IR[4:0]
//   PCload   out  load PC
//   Meminst  out  memory address: 0 = PC, 1 = IR[4:0]
//   MemWr    out  memory write strobe
//   Asel     out  A source: 00 = add/sub, 01 = input port, 10 = memory
//   Aload    out  load accumulator
//   Sub      out  1 = subtract
//   Halt     out  processor halted
//   State    out  current state code
//   Retired  out  retired-instruction count, wraps modulo 2^CNT_W
module inscyc_control_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       IR,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             Enter,
  output logic             IRload,
  output logic             JMPmux,
  output logic             PCload,
  output logic             Meminst,
  output logic             MemWr,
  output logic [1:0]       Asel,
  output logic             Aload,
  output logic             Sub,
  output logic             Halt,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // State register and retired-instruction counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_START;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_START;
    unique case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        unique case (IR)
          3'b000: w_next = S_LOAD;
          3'b001: w_next = S_STORE;
          3'b010: w_next = S_ADD;
          3'b011: w_next = S_SUB;
          3'b100: w_next = S_INPUT;
          3'b101: w_next = S_JZ;
          3'b110: w_next = S_JPOS;
          default: w_next = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: w_next = S_START;
      S_INPUT:  w_next = Enter ? S_START : S_INPUT;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_START;
    endcase
  end

  // An instruction retires when an execute state returns to START; HALT
  // counts once, on the DECODE->HALT transition, and never again while held.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_LOAD, S_STORE, S_ADD, S_SUB, S_INPUT, S_JZ, S_JPOS:
        w_retire = (w_next == S_START);
      S_DECODE:
        w_retire = (w_next == S_HALT);
      default:
        w_retire = 1'b0;
    endcase
  end

  // Output decode. Everything defaults to 0; each state lists only what it
  // asserts.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: begin
        Meminst = 1'b1;
      end
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_MEM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign State   = r_state;
  assign Retired = r_retired;

endmodule

// File: tb/tb_inscyc_control_unit.sv
module tb_inscyc_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] IR    = 3'b000;
  logic       Aeq0  = 1'b0;
  logic       Apos  = 1'b0;
  logic       Enter = 1'b0;

  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;
  logic [7:0] Retired;

  logic       IRload2, JMPmux2, PCload2, Meminst2, MemWr2, Aload2, Sub2, Halt2;
  logic [1:0] Asel2;
  logic [3:0] State2;
  logic [1:0] Retired2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Control word: {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,Halt}
  logic [9:0] cw;
  assign cw = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};

  localparam logic [9:0] CW_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] CW_FETCH  = 10'b10_1000_0000;
  localparam logic [9:0] CW_DECODE = 10'b00_0100_0000;
  localparam logic [9:0] CW_LOAD   = 10'b00_0101_0100;
  localparam logic [9:0] CW_STORE  = 10'b00_0110_0000;
  localparam logic [9:0] CW_ADD    = 10'b00_0100_0100;
  localparam logic [9:0] CW_SUB    = 10'b00_0100_0110;
  localparam logic [9:0] CW_IN_W   = 10'b00_0000_1000;
  localparam logic [9:0] CW_IN_E   = 10'b00_0000_1100;
  localparam logic [9:0] CW_JTAKEN = 10'b01_1000_0000;
  localparam logic [9:0] CW_JNOT   = 10'b01_0000_0000;
  localparam logic [9:0] CW_HALT   = 10'b00_0000_0001;

  inscyc_control_unit #(.CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
    .Enter(Enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
    .Sub(Sub), .Halt(Halt), .State(State), .Retired(Retired)
  );

  inscyc_control_unit #(.CNT_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos),
    .Enter(Enter), .IRload(IRload2), .JMPmux(JMPmux2), .PCload(PCload2),
    .Meminst(Meminst2), .MemWr(MemWr2), .Asel(Asel2), .Aload(Aload2),
    .Sub(Sub2), .Halt(Halt2), .State(State2), .Retired(Retired2)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    IR    = 3'b111;
    Enter = 1'b1;
    Aeq0  = 1'b1;
    Apos  = 1'b1;
    apply_reset();
    n_vec++;
    if (State !== 4'd0) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", State);
    end
    n_vec++;
    if (cw !== CW_NONE) begin
      n_err++; $display("FAIL reset_ctrl: got %b want %b", cw, CW_NONE);
    end
    n_vec++;
    if (Retired !== 8'd0 || Retired2 !== 2'd0) begin
      n_err++; $display("FAIL reset_retired: got %0d/%0d want 0/0", Retired, Retired2);
    end
    Enter = 1'b0;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
  endtask

  // Five LOADs back to back; also checks 8-bit and 2-bit counters.
  task automatic test_load();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd2, 4'd8};
    logic [9:0] cws[4] = '{CW_NONE, CW_FETCH, CW_DECODE, CW_LOAD};
    logic [1:0] r2 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    IR = 3'b000;
    apply_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      for (int unsigned p = 0; p < 4; p++) begin
        n_vec++;
        if (State !== st[p] || cw !== cws[p]) begin
          n_err++;
          $display("FAIL load_seq[%0d.%0d]: state=%0d cw=%b want state=%0d cw=%b",
                   k, p, State, cw, st[p], cws[p]);
        end
        if (p == 0) begin
          n_vec++;
          if (Retired !== 8'(k) || Retired2 !== r2[k]) begin
            n_err++;
            $display("FAIL load_retired[%0d]: got %0d/%0d want %0d/%0d",
                     k, Retired, Retired2, k, r2[k]);
          end
        end
        tick();
      end
    end
    n_vec++;
    if (State !== 4'd0 || Retired !== 8'd5 || Retired2 !== r2[5]) begin
      n_err++;
      $display("FAIL load_final: state=%0d ret=%0d ret2=%0d want 0/5/%0d",
               State, Retired, Retired2, r2[5]);
    end
  endtask

  // STORE, ADD, SUB back to back; IR is changed during EXEC to show it is ignored.
  task automatic test_back_to_back();
    logic [2:0] op [3] = '{3'b001, 3'b010, 3'b011};
    logic [3:0] es [3] = '{4'd9, 4'd10, 4'd11};
    logic [9:0] ec [3] = '{CW_STORE, CW_ADD, CW_SUB};
    apply_reset();
    for (int unsigned k = 0; k < 3; k++) begin
      IR = op[k];
      tick();
      tick();
      n_vec++;
      if (State !== 4'd2 || cw !== CW_DECODE) begin
        n_err++;
        $display("FAIL b2b_decode[%0d]: state=%0d cw=%b want 2 %b", k, State, cw, CW_DECODE);
      end
      tick();
      IR = 3'b111;
      #1;
      n_vec++;
      if (State !== es[k] || cw !== ec[k]) begin
        n_err++;
        $display("FAIL b2b_exec[%0d]: state=%0d cw=%b want %0d %b", k, State, cw, es[k], ec[k]);
      end
      tick();
      n_vec++;
      if (State !== 4'd0 || Retired !== 8'(k + 1)) begin
        n_err++;
        $display("FAIL b2b_done[%0d]: state=%0d ret=%0d want 0 %0d", k, State, Retired, k + 1);
      end
    end
  endtask

  task automatic test_jumps();
    logic [2:0] op   [4] = '{3'b101, 3'b101, 3'b110, 3'b110};
    logic       z    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       p    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] es   [4] = '{4'd13, 4'd13, 4'd14, 4'd14};
    logic [9:0] ec   [4] = '{CW_JTAKEN, CW_JNOT, CW_JTAKEN, CW_JNOT};
    apply_reset();
    for (int unsigned k = 0; k < 4; k++) begin
      IR   = op[k];
      Aeq0 = z[k];
      Apos = p[k];
      tick();
      tick();
      tick();
      n_vec++;
      if (State !== es[k] || cw !== ec[k]) begin
        n_err++;
        $display("FAIL jump[%0d]: state=%0d cw=%b want %0d %b", k, State, cw, es[k], ec[k]);
      end
      tick();
      n_vec++;
      if (State !== 4'd0 || Retired !== 8'(k + 1)) begin
        n_err++;
        $display("FAIL jump_done[%0d]: state=%0d ret=%0d want 0 %0d", k, State, Retired, k + 1);
      end
    end
    Aeq0 = 1'b0;
    Apos = 1'b0;
  endtask

  task automatic test_input();
    IR    = 3'b100;
    Enter = 1'b0;
    apply_reset();
    tick();
    tick();
    tick();
    for (int unsigned k = 0; k < 5; k++) begin
      n_vec++;
      if (State !== 4'd12 || cw !== CW_IN_W) begin
        n_err++;
        $display("FAIL input_wait[%0d]: state=%0d cw=%b want 12 %b", k, State, cw, CW_IN_W);
      end
      tick();
    end
    Enter = 1'b1;
    #1;
    n_vec++;
    if (State !== 4'd12 || cw !== CW_IN_E) begin
      n_err++;
      $display("FAIL input_enter: state=%0d cw=%b want 12 %b", State, cw, CW_IN_E);
    end
    tick();
    Enter = 1'b0;
    #1;
    n_vec++;
    if (State !== 4'd0 || Retired !== 8'd1) begin
      n_err++;
      $display("FAIL input_done: state=%0d ret=%0d want 0 1", State, Retired);
    end
    // Enter already high on entry: INPUT lasts one cycle.
    Enter = 1'b1;
    tick();
    tick();
    tick();
    n_vec++;
    if (State !== 4'd12 || cw !== CW_IN_E) begin
      n_err++;
      $display("FAIL input_pre: state=%0d cw=%b want 12 %b", State, cw, CW_IN_E);
    end
    tick();
    n_vec++;
    if (State !== 4'd0 || Retired !== 8'd2) begin
      n_err++;
      $display("FAIL input_pre_done: state=%0d ret=%0d want 0 2", State, Retired);
    end
    Enter = 1'b0;
  endtask

  task automatic test_halt();
    IR = 3'b111;
    apply_reset();
    tick();
    tick();
    tick();
    for (int unsigned k = 0; k < 20; k++) begin
      n_vec++;
      if (State !== 4'd15 || cw !== CW_HALT || Retired !== 8'd1) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: state=%0d cw=%b ret=%0d want 15 %b 1",
                 k, State, cw, Retired, CW_HALT);
      end
      IR    = 3'($urandom_range(7, 0));
      Enter = k[0];
      tick();
    end
    Enter = 1'b0;
    apply_reset();
    n_vec++;
    if (State !== 4'd0 || cw !== CW_NONE || Retired !== 8'd0) begin
      n_err++;
      $display("FAIL halt_reset: state=%0d cw=%b ret=%0d want 0 %b 0", State, cw, Retired, CW_NONE);
    end
  endtask

  task automatic test_reset_mid();
    IR = 3'b010;
    apply_reset();
    tick();
    tick();
    n_vec++;
    if (State !== 4'd2) begin
      n_err++; $display("FAIL mid_decode: state=%0d want 2", State);
    end
    apply_reset();
    n_vec++;
    if (State !== 4'd0 || cw !== CW_NONE || Retired !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset: state=%0d cw=%b ret=%0d want 0 %b 0", State, cw, Retired, CW_NONE);
    end
    tick();
    n_vec++;
    if (State !== 4'd1 || cw !== CW_FETCH) begin
      n_err++; $display("FAIL mid_fetch: state=%0d cw=%b want 1 %b", State, cw, CW_FETCH);
    end
    tick();
    tick();
    n_vec++;
    if (State !== 4'd10 || cw !== CW_ADD) begin
      n_err++; $display("FAIL mid_add: state=%0d cw=%b want 10 %b", State, cw, CW_ADD);
    end
    tick();
    n_vec++;
    if (State !== 4'd0 || Retired !== 8'd1) begin
      n_err++; $display("FAIL mid_done: state=%0d ret=%0d want 0 1", State, Retired);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_jumps();
    test_input();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inscyc_control_unit.md
# inscyc_control_unit

Control-unit FSM for the 8-bit EC-1-style processor. It sits directly upstream of the instruction-cycle datapath. It consumes the 3-bit opcode (IR[7:5]) latched by that datapath and the accumulator status flags. It drives the IR load, PC load, jump-mux and memory-address-mux selects, plus accumulator and memory controls, to sequence the start, fetch, decode and execute cycle of every instruction.

## Interface
Parameters:
- CNT_W, 8, width of the retired-instruction counter

Ports:
- Clock  in  1  single system clock, rising-edge
- Reset  in  1  synchronous, active-high; forces state START and clears counter
- IR  in  3  opcode, IR[7:5] from datapath instruction register
- Aeq0  in  1  accumulator == 0
- Apos  in  1  accumulator > 0 (signed, non-zero, MSB clear)
- Enter  in  1  user input-ready strobe
- IRload  out  1  load instruction register from memory
- JMPmux  out  1  PC source select: 0 = PC+1, 1 = IR[4:0]
- PCload  out  1  load PC
- Meminst  out  1  memory address select: 0 = PC, 1 = IR[4:0]
- MemWr  out  1  memory write strobe (store A)
- Asel  out  2  A source: 00 = adder/subtractor, 01 = input port, 10 = memory
- Aload  out  1  load accumulator
- Sub  out  1  adder/subtractor mode: 1 = subtract
- Halt  out  1  processor halted
- State  out  4  current state code (debug)
- Retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- Moore FSM with 4-bit state register. Encodings: START=0, FETCH=1, DECODE=2, LOAD=8, STORE=9, ADD=10, SUB=11, INPUT=12, JZ=13, JPOS=14, HALT=15. Unused codes go to START.
- Every output not listed for a state is 0.
- START: no outputs asserted. Next state FETCH.
- FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. Next state DECODE.
- DECODE: Meminst=1. Next state is selected by IR: 000 to LOAD, 001 to STORE, 010 to ADD, 011 to SUB, 100 to INPUT, 101 to JZ, 110 to JPOS, 111 to HALT.
- LOAD: Meminst=1, Asel=10, Aload=1. Next state START.
- STORE: Meminst=1, MemWr=1. Next state START.
- ADD: Meminst=1, Asel=00, Aload=1, Sub=0. Next state START.
- SUB: Meminst=1, Asel=00, Aload=1, Sub=1. Next state START.
- INPUT: Asel=01 and Aload=Enter; this Aload is the only Mealy term. If Enter=1 the next state is START, otherwise the FSM stays in INPUT.
- JZ: JMPmux=1 and PCload=Aeq0. Next state START.
- JPOS: JMPmux=1 and PCload=Apos. Next state START.
- HALT: Halt=1. The FSM holds here until Reset.
- Retired increments by 1 on every transition from an execute state (LOAD through JPOS) to START. Entering HALT also counts once. It wraps from 2^CNT_W−1 to 0.
- State output equals the state register.

## Timing
- Reset is sampled on the rising Clock edge. After that edge: State=0, Retired=0, and every control output is 0. Reset overrides all transitions, including mid-instruction and HALT.
- The datapath shares the same Clock and Reset.
- Latency:
  - Non-INPUT instruction: 4 cycles (START, FETCH, DECODE, EXEC).
  - INPUT: 4 + N cycles, where N is the number of cycles Enter stays low in INPUT.
  - HALT is entered after 3 cycles.
- IR is sampled only in DECODE; FETCH's edge has already latched it. A change on IR outside DECODE has no effect.
- Aeq0 and Apos are sampled combinationally in JZ/JPOS. They must reflect the accumulator as updated by the previous instruction.
- In INPUT, an Enter pulse of one cycle is sufficient. Enter is level-sensitive, so an Enter already high on entry completes INPUT in 1 cycle.
- The PC load in FETCH (PC+1) and the IR load coincide on the same edge.

## Test plan
- Reset, then IR=000 held: State sequence 0,1,2,8,0,1…; Aload=1 with Asel=10 only in state 8; Retired=1 after the first return to 0.
- IR=101 with Aeq0=1: in state 13, JMPmux=1 and PCload=1. Repeat with Aeq0=0: PCload=0 and JMPmux=1.
- IR=100 with Enter low for 5 cycles then high for 1: State holds at 12 for 6 cycles; Aload=1 only in the Enter cycle; then State=0.
- IR=111: State reaches 15 and Halt=1 stays high for 20 cycles regardless of IR and Enter. Then Reset=1 for 1 cycle gives State=0, Halt=0, Retired=0.
- Assert Reset while in DECODE (State=2): at the next edge State=0 and all controls are 0. The next instruction then starts cleanly.
- CNT_W=2, run 5 LOAD instructions: Retired counts 1,2,3,0,1.
